// File: rtl/oled_pkg.sv
// Shared constants, controller opcodes and streamer state encoding
// for the OLED framebuffer-to-display path.
package oled_pkg;

  localparam int H_PIXELS = 128;
  localparam int V_PIXELS = 64;
  localparam int PAGES    = V_PIXELS / 8;

  localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_COL_HI   = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FB,
    S_CMD,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/oled_byte_slot.sv
// One-entry valid/ready holding register for a display byte and its dc flag.
// Reloads in the same cycle it drains, so a full stream needs no bubbles.
module oled_byte_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_dc,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_dc,
  output logic       free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_dc    <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_dc    <= load_dc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/oled_page_streamer.sv
// Walks the framebuffer page by page with column reads and streams
// GDDRAM bytes (optionally led by page/column commands) to the SPI driver.
module oled_page_streamer #(
  parameter int H_PIXELS       = oled_pkg::H_PIXELS,
  parameter int V_PIXELS       = oled_pkg::V_PIXELS,
  parameter bit EMIT_PAGE_CMDS = 1'b1,
  parameter int COL_OFFSET     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  input  logic       fb_ready,
  input  logic       fb_busy,
  output logic       fb_re,
  output logic [7:0] fb_r_xpos,
  output logic [7:0] fb_r_ypos,
  output logic       fb_r_mode,
  input  logic       fb_r_data_valid,
  input  logic [7:0] fb_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_dc
);

  import oled_pkg::*;

  localparam logic [6:0] LAST_COL  = 7'(H_PIXELS - 1);
  localparam logic [2:0] LAST_PAGE = 3'(V_PIXELS / 8 - 1);
  localparam logic [7:0] COL_OFF   = 8'(COL_OFFSET);

  state_t     state;
  logic [2:0] page;
  logic [6:0] col;
  logic [1:0] cmd_idx;
  logic       slot_free;
  logic       ld;
  logic       ld_dc;
  logic [7:0] ld_data;
  logic [7:0] cmd_byte;

  assign fb_r_xpos = {1'b0, col};
  assign fb_r_ypos = {2'b00, page, 3'b000};
  assign fb_r_mode = 1'b1;

  always_comb begin
    cmd_byte = CMD_SET_PAGE | {5'b0, page};
    case (cmd_idx)
      2'd1:    cmd_byte = CMD_COL_LO | {4'b0, COL_OFF[3:0]};
      2'd2:    cmd_byte = CMD_COL_HI | {4'b0, COL_OFF[7:4]};
      default: cmd_byte = CMD_SET_PAGE | {5'b0, page};
    endcase
  end

  always_comb begin
    ld      = 1'b0;
    ld_data = cmd_byte;
    ld_dc   = 1'b0;
    if (state == S_CMD && slot_free) begin
      ld = 1'b1;
    end
    if (state == S_RD_WAIT && fb_r_data_valid && slot_free) begin
      ld      = 1'b1;
      ld_data = fb_dout;
      ld_dc   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      fb_re      <= 1'b0;
      page       <= 3'd0;
      col        <= 7'd0;
      cmd_idx    <= 2'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            page    <= 3'd0;
            col     <= 7'd0;
            cmd_idx <= 2'd0;
            state   <= S_WAIT_FB;
          end
        end
        S_WAIT_FB: begin
          if (fb_ready) begin
            cmd_idx <= 2'd0;
            state   <= EMIT_PAGE_CMDS ? S_CMD : S_RD_REQ;
          end
        end
        S_CMD: begin
          if (slot_free) begin
            if (cmd_idx == 2'd2) begin
              cmd_idx <= 2'd0;
              state   <= S_RD_REQ;
            end else begin
              cmd_idx <= cmd_idx + 2'd1;
            end
          end
        end
        // never start a read on top of an in-flight write
        S_RD_REQ: begin
          if (!fb_busy) begin
            fb_re <= 1'b1;
            state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (fb_r_data_valid && slot_free) begin
            fb_re <= 1'b0;
            state <= S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          if (col == LAST_COL) begin
            col <= 7'd0;
            if (page == LAST_PAGE) begin
              state <= S_DONE;
            end else begin
              page  <= page + 3'd1;
              state <= EMIT_PAGE_CMDS ? S_CMD : S_RD_REQ;
            end
          end else begin
            col   <= col + 7'd1;
            state <= S_RD_REQ;
          end
        end
        S_DONE: begin
          if (slot_free) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  oled_byte_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_data (ld_data),
    .load_dc   (ld_dc),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_dc    (out_dc),
    .free      (slot_free)
  );

endmodule

// File: tb/tb_oled_page_streamer.sv
// Scoreboard bench for oled_page_streamer: a pixel-array framebuffer model
// feeds the DUT; expected byte streams are built per frame from the pixels.
module tb_oled_page_streamer;

  localparam int LAT = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, busy, frame_done;
  logic       fb_ready, fb_busy, fb_re, fb_r_mode;
  logic [7:0] fb_r_xpos, fb_r_ypos, fb_dout;
  logic       fb_r_data_valid;
  logic       out_valid, out_ready, out_dc;
  logic [7:0] out_data;

  logic       start_b, busy_b, frame_done_b, fb_re_b, fb_r_mode_b;
  logic [7:0] fb_r_xpos_b, fb_r_ypos_b, out_data_b;
  logic       fb_r_data_valid_b, out_valid_b, out_dc_b;
  logic       fb_ready_b, fb_busy_b, out_ready_b;
  logic [7:0] fb_dout_b;

  assign fb_ready_b        = 1'b1;
  assign fb_busy_b         = 1'b0;
  assign out_ready_b       = 1'b1;
  assign fb_dout_b         = 8'h00;
  assign fb_r_data_valid_b = fb_re_b;

  oled_page_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .frame_done(frame_done), .fb_ready(fb_ready), .fb_busy(fb_busy),
    .fb_re(fb_re), .fb_r_xpos(fb_r_xpos), .fb_r_ypos(fb_r_ypos),
    .fb_r_mode(fb_r_mode), .fb_r_data_valid(fb_r_data_valid),
    .fb_dout(fb_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dc(out_dc)
  );

  oled_page_streamer #(.COL_OFFSET(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .frame_done(frame_done_b), .fb_ready(fb_ready_b), .fb_busy(fb_busy_b),
    .fb_re(fb_re_b), .fb_r_xpos(fb_r_xpos_b), .fb_r_ypos(fb_r_ypos_b),
    .fb_r_mode(fb_r_mode_b), .fb_r_data_valid(fb_r_data_valid_b),
    .fb_dout(fb_dout_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_dc(out_dc_b)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0]  exp_q[$];
  logic [63:0] pix[128];
  bit   armed = 1'b0;
  int   done_cnt = 0;
  int   hs_cnt = 0;
  bit   freeze = 1'b0;
  bit   rmode = 1'b0;
  bit   bmode = 1'b0;
  bit   busy_force = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // expected stream: per page 3 commands, then one byte per column
  task automatic push_frame(int coloff);
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
      exp_q.push_back({1'b0, 8'(coloff % 16)});
      exp_q.push_back({1'b0, 8'h10 | 8'(coloff / 16)});
      for (int c = 0; c < 128; c++)
        exp_q.push_back({1'b1, pix[c][p*8 +: 8]});
    end
  endtask

  task automatic wait_done(int target, int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      tick(1);
      n++;
    end
    check("frame_done_seen", done_cnt, target);
  endtask

  // framebuffer: dout valid after LAT cycles of continuous fb_re
  int         fb_cnt = 0;
  logic [7:0] lx, ly;
  initial begin
    fb_r_data_valid = 1'b0;
    fb_dout = 8'h00;
    lx = 8'h00;
    ly = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (fb_re) begin
        fb_cnt++;
        if (fb_cnt == 1) begin
          lx = fb_r_xpos;
          ly = fb_r_ypos;
        end else begin
          check("addr_stable", {fb_r_xpos, fb_r_ypos}, {lx, ly});
        end
      end else begin
        fb_cnt = 0;
      end
      fb_r_data_valid = fb_re && (fb_cnt >= LAT);
      if (fb_r_data_valid) fb_dout = pix[lx[6:0]][ly[5:0] +: 8];
      else fb_dout = 8'($urandom);
    end
  end

  int   r_run = 0;
  logic r_val = 1'b1;
  initial begin
    out_ready = 1'b1;
    fb_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (r_run == 0) begin
        r_val = 1'($urandom % 2);
        r_run = $urandom_range(1, 24);
      end
      r_run--;
      out_ready = freeze ? 1'b0 : (rmode ? r_val : 1'b1);
      fb_busy = busy_force || (bmode && ($urandom_range(0, 3) == 0));
    end
  end

  logic       pv = 0, pr = 0, pre = 0, pbusy = 0, pdv = 0, prst = 1;
  logic [8:0] pbyte = 9'h0;
  always @(negedge clk) begin
    if (!rst && !prst) begin
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_byte", {out_dc, out_data}, pbyte);
      end
      if (fb_re && !pre) check("re_busy_gate", pbusy, 0);
      if (pre && !(pdv && (!pv || pr))) check("re_held", fb_re, 1);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %h expected none", {out_dc, out_data});
        end else begin
          check("byte", {out_dc, out_data}, exp_q.pop_front());
        end
      end
      if (frame_done) begin
        check("done_armed", armed, 1);
        check("done_queue_empty", exp_q.size(), 0);
        done_cnt++;
        armed = 1'b0;
      end
    end
    pv = out_valid;
    pr = out_ready;
    pre = fb_re;
    pbusy = fb_busy;
    pdv = fb_r_data_valid;
    prst = rst;
    pbyte = {out_dc, out_data};
  end

  logic [7:0] cb[3] = '{8'hB0, 8'h02, 8'h10};
  int n_b = 0;
  int done_b = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_b) begin
        n_b++;
        if (n_b <= 3)
          check("b_cmd", {out_dc_b, out_data_b}, {1'b0, cb[n_b-1]});
      end
      if (frame_done_b) begin
        done_b++;
        check("b_frame_bytes", n_b, 1048);
      end
    end
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    fb_ready = 1'b1;
    for (int c = 0; c < 128; c++) pix[c] = 64'h0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_re", fb_re, 0);
    check("rst_xpos", fb_r_xpos, 0);
    check("rst_ypos", fb_r_ypos, 0);
    check("rst_mode", fb_r_mode, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_dc", out_dc, 0);
    rst = 1'b0;
    tick(2);

    // frame 1: blank frame, full throughput, one forced fb_busy window
    push_frame(0);
    armed = 1'b1;
    base = hs_cnt;
    start = 1'b1;
    start_b = 1'b1;
    tick(1);
    start = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (hs_cnt - base < 10 && n < 2000) begin tick(1); n++; end
    n = 0;
    while (!fb_re && n < 100) begin tick(1); n++; end
    while (fb_re && n < 100) begin tick(1); n++; end
    check("saw_read_gap", fb_re, 0);
    busy_force = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("re_blocked_by_busy", fb_re, 0);
    end
    busy_force = 1'b0;
    n = 0;
    while (!fb_re && n < 4) begin tick(1); n++; end
    check("re_after_busy", fb_re, 1);
    wait_done(1, 30000);
    check("frame1_bytes", hs_cnt - base, 1048);
    check("busy_after_done", busy, 0);
    check("b_done", done_b, 1);

    // frame 2: random pixels, stalls, fb_busy noise, late fb_ready
    for (int c = 0; c < 128; c++) pix[c] = {$urandom, $urandom};
    pix[5][15:8] = 8'h81;
    rmode = 1'b1;
    bmode = 1'b1;
    fb_ready = 1'b0;
    push_frame(0);
    armed = 1'b1;
    base = hs_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      check("nofb_re", fb_re, 0);
      check("nofb_valid", out_valid, 0);
      check("nofb_busy", busy, 1);
      tick(1);
    end
    fb_ready = 1'b1;
    n = 0;
    while (hs_cnt - base < 300 && n < 20000) begin tick(1); n++; end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(2, 40000);
    check("frame2_bytes", hs_cnt - base, 1048);

    // frame 3: aborted by reset at page 3, col 40
    rmode = 1'b0;
    bmode = 1'b0;
    for (int c = 0; c < 128; c++) pix[c] = {$urandom, $urandom};
    push_frame(0);
    armed = 1'b1;
    base = hs_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (hs_cnt - base < 3 * 131 + 3 + 40 && n < 20000) begin
      tick(1);
      n++;
    end
    check("abort_point", hs_cnt - base, 3 * 131 + 3 + 40);
    rst = 1'b1;
    freeze = 1'b1;
    tick(1);
    check("abort_re", fb_re, 0);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    freeze = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    tick(100);
    check("abort_no_done", done_cnt, 2);

    // frame 4: clean restart from page 0
    push_frame(0);
    armed = 1'b1;
    base = hs_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(3, 30000);
    check("frame4_bytes", hs_cnt - base, 1048);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_page_streamer.md
Name: oled_page_streamer

Overview:
- Downstream consumer of the monochrome framebuffer; walks a 128x64 frame page by page.
- Issues column-mode reads (8 vertical pixels per byte, bit0 = top row) and streams the results as SSD1306/SH1106 GDDRAM bytes to the SPI byte driver over a valid/ready interface.
- Optionally precedes each page with page/column address command bytes (dc=0); pixel bytes use dc=1.

Parameters:
- H_PIXELS, 128, columns per page.
- V_PIXELS, 64, rows; PAGES = V_PIXELS/8.
- EMIT_PAGE_CMDS, 1, 1 = emit 3 command bytes before each page; 0 = data bytes only.
- COL_OFFSET, 0, controller column offset placed in the column-address commands (2 for SH1106).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  one-cycle request to stream one full frame
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last data byte handshakes
- fb_ready  in  1  framebuffer clear complete (rst_complete)
- fb_busy  in  1  framebuffer busy
- fb_re  out  1  framebuffer read enable
- fb_r_xpos  out  8  read column
- fb_r_ypos  out  8  read row = page*8
- fb_r_mode  out  1  constant 1 (column read)
- fb_r_data_valid  in  1  framebuffer dout valid
- fb_dout  in  8  column byte, LSB = top row
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  byte to display
- out_dc  out  1  0 = command, 1 = data

Behaviour:
- Reset: all outputs 0 (busy, frame_done, fb_re, fb_r_xpos, fb_r_ypos, out_valid, out_data, out_dc); fb_r_mode = 1; FSM enters IDLE. Reset mid-frame aborts the frame; no frame_done is produced.
- Output slot:
  - One-entry register. A byte transfers when out_valid && out_ready.
  - out_data and out_dc stay stable while out_valid && !out_ready.
  - The slot may load in the same cycle it is drained (full throughput).
- FSM states:
  - IDLE: start -> WAIT_FB; busy <= 1; page <= 0, col <= 0. start is ignored while busy.
  - WAIT_FB: wait for fb_ready = 1, then go to CMD if EMIT_PAGE_CMDS, else RD_REQ.
  - CMD: load 3 bytes in order, dc=0, one per free slot:
    - 0xB0|page
    - 0x00|(COL_OFFSET & 0xF)
    - 0x10|(COL_OFFSET >> 4)
    Then go to RD_REQ.
  - RD_REQ: drive xpos = col, ypos = page*8. Assert fb_re only in a cycle where fb_busy == 0, then go to RD_WAIT; otherwise stay.
  - RD_WAIT:
    - Hold fb_re = 1 with addresses stable until fb_r_data_valid = 1 and the slot is free (or draining this cycle).
    - Then load fb_dout with dc=1 into the slot and go to RD_GAP.
    - fb_re stays high while the slot is blocked; the framebuffer keeps dout valid, so no re-read is needed.
  - RD_GAP:
    - fb_re = 0 for exactly one cycle, which clears the framebuffer read pipeline.
    - Advance position: col+1. At col = H_PIXELS-1, col <= 0 and page+1. Then go to CMD/RD_REQ.
    - After page PAGES-1, col H_PIXELS-1, go to DONE.
  - DONE: wait for the slot to drain, pulse frame_done, busy <= 0, go to IDLE.
- Latency: no fixed latency is assumed; the block relies only on the fb_r_data_valid handshake. The framebuffer's column read currently takes 11 cycles, so the nominal frame time is PAGES*H_PIXELS*(11+2) cycles plus command bytes.
- Write arbitration: the framebuffer suspends writes while fb_re is high. The fb_busy gate in RD_REQ avoids interrupting an in-flight write.
- Widths: page is 3 bits and col is 7 bits; both counters wrap explicitly. fb_r_ypos = {page, 3'b000}, zero-extended.
- Simultaneous start and rst: rst wins.

Decomposition:
- Package oled_pkg holds:
  - H_PIXELS, V_PIXELS, PAGES.
  - Command opcodes CMD_SET_PAGE = 0xB0, CMD_COL_LO = 0x00, CMD_COL_HI = 0x10.
  - The FSM state enum.
- Sub-module oled_byte_slot: the one-entry valid/ready holding register (data+dc), shared with the init-sequence block.

Test Plan:
- Reset, then start with fb_ready=1, out_ready=1, framebuffer model with all bytes 0 -> first three bytes are 0xB0, 0x00, 0x10 with dc=0. Then 128 data bytes of 0x00 with dc=1. Then page 1 begins with 0xB1. frame_done fires once after 8*131 = 1048 byte handshakes.
- Framebuffer column at x=5, rows 8..15, holds pattern 1,0,0,0,0,0,0,1 -> page-1 data byte #5 is 0x81.
- out_ready toggled randomly 50% -> no byte lost or duplicated. out_data is stable while stalled. fb_re stays high during a blocked RD_WAIT.
- fb_busy held high for 20 cycles in RD_REQ -> fb_re stays 0 for those cycles, then the read proceeds. fb_re always shows a one-cycle low gap between reads.
- start while fb_ready=0 for 50 cycles -> no fb_re and no out_valid until fb_ready rises. start pulsed again mid-frame -> ignored.
- rst asserted at page 3, col 40 -> next cycle fb_re=0, out_valid=0, busy=0, no frame_done. A new start restarts from page 0 with 0xB0. With COL_OFFSET=2, the command bytes are 0x02 and 0x10.
